// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encoding, framebuffer geometry, writer FSM states
// and the pixel FIFO entry layout.
package ppu_pkg;

    typedef enum logic [1:0] {
        MODE_H_BLANK = 2'd0,
        MODE_V_BLANK = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_DRAW    = 2'd3
    } ppu_mode_t;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 144;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_DRAIN,
        WR_SWAP
    } fb_wr_state_t;

    typedef struct packed {
        logic [1:0] shade;
        logic [7:0] x;
        logic [7:0] y;
    } px_entry_t;

    // y*160 + x using shifts only: 160 = 128 + 32.
    function automatic logic [14:0] fb_pixel_addr(input logic [7:0] x, input logic [7:0] y);
        return (15'(y) << 7) + (15'(y) << 5) + 15'(x);
    endfunction

endpackage

// File: rtl/ppu_px_fifo.sv
// Synchronous show-ahead FIFO for queued framebuffer pixels; the head entry is
// visible on dout whenever empty is low.
module ppu_px_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ppu_fb_writer.sv
// Converts PPU background pixels into palette shades and queues them as
// framebuffer writes into the back bank, swapping banks once per frame.
module ppu_fb_writer
    import ppu_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  px_in,
    input  logic        px_valid,
    input  logic [1:0]  ppu_mode,
    input  logic [7:0]  bgp,
    input  logic        lcd_en,
    output logic        fb_wr_en,
    output logic [15:0] fb_wr_addr,
    output logic [1:0]  fb_wr_data,
    input  logic        fb_wr_ready,
    output logic        fb_bank,
    output logic        frame_done,
    output logic        overflow
);

    fb_wr_state_t state;
    ppu_mode_t    mode_now;
    ppu_mode_t    mode_q;
    logic [7:0]   x_cnt;
    logic [7:0]   y_cnt;

    logic         scan_entry;
    logic         vblank_entry;
    logic         line_end;
    logic         in_range;
    logic [1:0]   shade;
    logic         push_req;
    logic         push_ok;
    logic         pop;
    px_entry_t    push_entry;
    px_entry_t    head;
    logic         fifo_full;
    logic         fifo_empty;

    assign mode_now     = ppu_mode_t'(ppu_mode);
    assign scan_entry   = (mode_now == MODE_SCAN) && (mode_q != MODE_SCAN);
    assign vblank_entry = (mode_now == MODE_V_BLANK) && (mode_q != MODE_V_BLANK);
    assign line_end     = (mode_q == MODE_DRAW) && (mode_now == MODE_H_BLANK);
    assign in_range     = (x_cnt < 8'(FB_WIDTH)) && (y_cnt < 8'(FB_HEIGHT));
    assign shade        = bgp[{px_in, 1'b0} +: 2];

    assign push_req   = px_valid && lcd_en && in_range && (state == WR_ACTIVE);
    assign pop        = fb_wr_en && fb_wr_ready;
    assign push_ok    = !fifo_full || pop;
    assign push_entry = '{shade: shade, x: x_cnt, y: y_cnt};

    ppu_px_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(px_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!lcd_en),
        .push  (push_req),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head fields are masked while empty so idle outputs read as zero.
    assign fb_wr_en   = !fifo_empty;
    assign fb_wr_data = fifo_empty ? 2'd0 : head.shade;
    assign fb_wr_addr = {fb_bank, fifo_empty ? 15'd0 : fb_pixel_addr(head.x, head.y)};

    // Counters saturate so a runaway line cannot wrap back into the visible area.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_H_BLANK;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            mode_q <= mode_now;
            if (!lcd_en) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else begin
                if (scan_entry) begin
                    x_cnt <= '0;
                end else if (px_valid && (x_cnt != 8'hFF)) begin
                    x_cnt <= x_cnt + 8'd1;
                end
                if (vblank_entry) begin
                    y_cnt <= '0;
                end else if (line_end && (y_cnt != 8'hFF)) begin
                    y_cnt <= y_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WR_IDLE;
            fb_bank    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            if (!lcd_en) begin
                state <= WR_IDLE;
            end else begin
                case (state)
                    WR_IDLE: begin
                        if (mode_now == MODE_SCAN) begin
                            state <= WR_ACTIVE;
                        end
                    end
                    WR_ACTIVE: begin
                        if (vblank_entry) begin
                            state <= WR_DRAIN;
                        end
                    end
                    WR_DRAIN: begin
                        if (fifo_empty) begin
                            state      <= WR_SWAP;
                            fb_bank    <= ~fb_bank;
                            frame_done <= 1'b1;
                        end
                    end
                    WR_SWAP: begin
                        state <= WR_ACTIVE;
                    end
                    default: begin
                        state <= WR_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Randomised scoreboard bench for ppu_fb_writer: a line/frame level pixel model
// predicts every framebuffer write, and a monitor pops and compares each one.
module tb_ppu_fb_writer;

    localparam int DEPTH = 16;
    localparam logic [1:0] H_BLANK = 2'd0;
    localparam logic [1:0] V_BLANK = 2'd1;
    localparam logic [1:0] SCAN    = 2'd2;
    localparam logic [1:0] DRAW    = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  px_in;
    logic        px_valid;
    logic [1:0]  ppu_mode;
    logic [7:0]  bgp;
    logic        lcd_en;
    logic        fb_wr_en;
    logic [15:0] fb_wr_addr;
    logic [1:0]  fb_wr_data;
    logic        fb_wr_ready;
    logic        fb_bank;
    logic        frame_done;
    logic        overflow;

    int          checks = 0;
    int          failures = 0;
    logic [17:0] sbq[$];
    logic [1:0]  px_list[$];
    int          m_x;
    int          m_y;
    bit          m_bank;
    bit          m_ovf;
    int          writes = 0;
    int          fd_count = 0;
    logic [15:0] last_addr = '0;
    bit          seen_325 = 1'b0;

    always #5 clk = ~clk;

    ppu_fb_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .px_in       (px_in),
        .px_valid    (px_valid),
        .ppu_mode    (ppu_mode),
        .bgp         (bgp),
        .lcd_en      (lcd_en),
        .fb_wr_en    (fb_wr_en),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .fb_wr_ready (fb_wr_ready),
        .fb_bank     (fb_bank),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int pct);
        fb_wr_ready = ($urandom_range(99) < pct);
    endtask

    // Drives one pixel slot and predicts its fate from queue occupancy and position.
    task automatic applyStimulus(input bit valid, input logic [1:0] px);
        int qs;
        bit pop_now;
        px_valid = valid;
        px_in    = px;
        if (valid) begin
            qs      = sbq.size();
            pop_now = (qs > 0) && fb_wr_ready;
            if (m_x < 160 && m_y < 144) begin
                if (qs < DEPTH || pop_now)
                    sbq.push_back({m_bank, 15'(m_y * 160 + m_x), 2'((bgp >> (2 * px)) & 8'h3)});
                else
                    m_ovf = 1'b1;
            end
            m_x++;
        end
    endtask

    task automatic run_line(input int n, input int ready_pct, input int valid_pct,
                            input bit use_list, input bit check_lat, input bit end_line);
        int sent;
        bit lat_done;
        bit valid;
        sent     = 0;
        lat_done = 1'b0;
        tick();
        ppu_mode = SCAN;
        applyStimulus(1'b0, 2'd0);
        set_ready(ready_pct);
        m_x = 0;
        tick();
        set_ready(ready_pct);
        while (sent < n) begin
            tick();
            ppu_mode = DRAW;
            set_ready(ready_pct);
            if (check_lat && sent == 1 && !lat_done) begin
                checkOutput("latency_wr_en", fb_wr_en, 1);
                lat_done = 1'b1;
            end
            valid = use_list || ($urandom_range(99) < valid_pct);
            if (valid) begin
                applyStimulus(1'b1, use_list ? px_list[sent] : 2'($urandom_range(3)));
                sent++;
            end else begin
                applyStimulus(1'b0, 2'd0);
            end
        end
        tick();
        applyStimulus(1'b0, 2'd0);
        if (end_line) begin
            ppu_mode = H_BLANK;
            set_ready(ready_pct);
            m_y++;
            tick();
            set_ready(ready_pct);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() > 0 && k < 400) begin
            tick();
            fb_wr_ready = 1'b1;
            k++;
        end
        tick();
        tick();
        checkOutput("drain_pending", sbq.size(), 0);
        checkOutput("overflow_flag", overflow, m_ovf);
    endtask

    task automatic do_vblank();
        bit found;
        tick();
        ppu_mode    = V_BLANK;
        fb_wr_ready = 1'b0;
        applyStimulus(1'b0, 2'd0);
        m_y = 0;
        repeat (4) begin
            tick();
            checkOutput("frame_done_early", frame_done, 0);
        end
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (frame_done) found = 1'b1;
            fb_wr_ready = 1'b1;
        end
        checkOutput("frame_done_seen", found, 1);
        if (found) begin
            checkOutput("pending_at_swap", sbq.size(), 0);
            checkOutput("bank_after_swap", fb_bank, !m_bank);
            m_bank = !m_bank;
            tick();
            checkOutput("frame_done_width", frame_done, 0);
        end
        tick();
    endtask

    // Monitor: every accepted write is matched against the scoreboard head.
    always @(negedge clk) begin
        logic [17:0] exp_w;
        if (!rst) begin
            if (frame_done) fd_count++;
            if (fb_wr_en && fb_wr_ready) begin
                writes++;
                last_addr = fb_wr_addr;
                if (fb_wr_addr == 16'd325 && fb_wr_data == 2'd3) seen_325 = 1'b1;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write actual addr=%0d data=%0d required no write",
                             fb_wr_addr, fb_wr_data);
                end else begin
                    exp_w = sbq.pop_front();
                    checkOutput("wr_addr", fb_wr_addr, exp_w[17:2]);
                    checkOutput("wr_data", fb_wr_data, exp_w[1:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0;
        rst         = 1'b1;
        px_valid    = 1'b0;
        px_in       = 2'd0;
        ppu_mode    = H_BLANK;
        bgp         = 8'hE4;
        lcd_en      = 1'b1;
        fb_wr_ready = 1'b0;
        m_x = 0; m_y = 0; m_bank = 1'b0; m_ovf = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("rst_wr_en", fb_wr_en, 0);
        checkOutput("rst_addr", fb_wr_addr, 0);
        checkOutput("rst_data", fb_wr_data, 0);
        checkOutput("rst_bank", fb_bank, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // Line 0: identity palette, shades 0..3 at x=0..3.
        w0 = writes;
        bgp = 8'hE4;
        px_list = {2'd0, 2'd1, 2'd2, 2'd3};
        run_line(4, 100, 100, 1'b1, 1'b1, 1'b1);
        drain();
        checkOutput("line0_writes", writes - w0, 4);
        checkOutput("line0_last_addr", last_addr, 3);

        bgp = 8'($urandom);
        run_line(10, 100, 70, 1'b0, 1'b0, 1'b1);
        drain();

        // Line 2: inverted palette, x=5 carries colour 0.
        bgp = 8'h1B;
        px_list = {2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
        run_line(6, 100, 100, 1'b1, 1'b0, 1'b1);
        drain();
        checkOutput("addr325_data3", seen_325, 1);

        // Line 3: writes stalled for 20 pixels.
        w0 = writes;
        bgp = 8'hE4;
        run_line(20, 0, 100, 1'b0, 1'b0, 1'b1);
        checkOutput("overflow_stalled", overflow, 1);
        drain();
        checkOutput("stall_writes", writes - w0, 16);

        // Line 4: over-long line is clipped at x=159.
        w0 = writes;
        run_line(168, 100, 100, 1'b0, 1'b0, 1'b1);
        drain();
        checkOutput("long_line_writes", writes - w0, 160);
        checkOutput("long_line_last_addr", last_addr, 4 * 160 + 159);

        for (int l = 0; l < 5; l++) begin
            bgp = 8'($urandom);
            run_line($urandom_range(40, 170), 60, 75, 1'b0, 1'b0, 1'b1);
            drain();
        end

        // Three writes pending at V_BLANK entry.
        w0 = writes;
        run_line(3, 0, 100, 1'b0, 1'b0, 1'b1);
        do_vblank();
        checkOutput("vblank_writes", writes - w0, 3);

        bgp = 8'($urandom);
        run_line(20, 100, 100, 1'b0, 1'b0, 1'b1);
        drain();
        checkOutput("bank1_addr_bit15", last_addr[15], 1);

        // LCD switched off mid-line with writes queued.
        run_line(8, 0, 100, 1'b0, 1'b0, 1'b0);
        lcd_en      = 1'b0;
        fb_wr_ready = 1'b0;
        ppu_mode    = H_BLANK;
        sbq.delete();
        m_x = 0;
        m_y = 0;
        tick();
        checkOutput("wr_en_after_lcd_off", fb_wr_en, 0);
        w0 = writes;
        repeat (5) begin
            fb_wr_ready = 1'b1;
            tick();
        end
        checkOutput("writes_lcd_off", writes - w0, 0);
        lcd_en = 1'b1;
        tick();
        checkOutput("bank_retained", fb_bank, m_bank);
        checkOutput("overflow_retained", overflow, m_ovf);
        bgp = 8'($urandom);
        run_line(30, 80, 80, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset mid-frame with unacknowledged writes.
        run_line(5, 0, 100, 1'b0, 1'b0, 1'b0);
        rst         = 1'b1;
        fb_wr_ready = 1'b0;
        ppu_mode    = H_BLANK;
        sbq.delete();
        m_x = 0; m_y = 0; m_bank = 1'b0; m_ovf = 1'b0;
        tick();
        tick();
        checkOutput("midrst_wr_en", fb_wr_en, 0);
        checkOutput("midrst_addr", fb_wr_addr, 0);
        checkOutput("midrst_bank", fb_bank, 0);
        checkOutput("midrst_overflow", overflow, 0);
        rst = 1'b0;
        tick();
        w0 = writes;
        bgp = 8'hE4;
        px_list = {2'd3};
        run_line(1, 100, 100, 1'b1, 1'b0, 1'b1);
        drain();
        checkOutput("post_rst_writes", writes - w0, 1);
        checkOutput("post_rst_addr", last_addr, 0);
        checkOutput("frame_done_count", fd_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ppu_fb_writer.md
PPU_FB_WRITER -- requirements
Module: ppu_fb_writer

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: px_in  in  2  background colour index from PPU shifter.
REQ-004 SHALL have port: px_valid  in  1  px_in valid this cycle; no backpressure to PPU.
REQ-005 SHALL have port: ppu_mode  in  2  PPU mode (H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3).
REQ-006 SHALL have port: bgp  in  8  BGP palette register (FF47).
REQ-007 SHALL have port: lcd_en  in  1  LCDC[7].
REQ-008 SHALL have port: fb_wr_en  out  1  framebuffer write request.
REQ-009 SHALL have port: fb_wr_addr  out  16  bit 15 = bank, [14:0] = y*160+x.
REQ-010 SHALL have port: fb_wr_data  out  2  shade.
REQ-011 SHALL have port: fb_wr_ready  in  1  framebuffer accepts write this cycle.
REQ-012 SHALL have port: fb_bank  out  1  bank being written; display reads ~fb_bank.
REQ-013 SHALL have port: frame_done  out  1  one-cycle pulse after bank swap.
REQ-014 SHALL have port: overflow  out  1  sticky: pixel dropped because FIFO full.
REQ-015 SHALL have parameter: FIFO_DEPTH, default 16, pixel FIFO entries (power of 2).

Function
REQ-016 SHALL map shade = bgp[2*px_in+1 : 2*px_in], sampled in the cycle px_valid is high.
REQ-017 SHALL keep x_cnt (8b) and y_cnt (8b): x_cnt +1 per accepted-or-dropped valid pixel, cleared on entry to SCAN; y_cnt +1 on DRAW->H_BLANK transition, cleared on entry to V_BLANK.
REQ-018 SHALL discard (no push, no overflow) pixels with x_cnt >= 160 or y_cnt >= 144.
REQ-019 SHALL push {shade, x_cnt, y_cnt} when px_valid && lcd_en && in-range && state==ACTIVE.
REQ-020 SHALL accept a push when full only if a pop occurs the same cycle; otherwise drop the pixel and set overflow.
REQ-021 SHALL present FIFO head as fb_wr_en=1 whenever non-empty; pop on fb_wr_en && fb_wr_ready; outputs stable while not ready.
REQ-022 SHALL compute address as (y<<7)+(y<<5)+x, range 0..23039, bit 15 = fb_bank.
REQ-023 SHALL have minimum latency of one cycle: pixel valid at cycle N gives fb_wr_en at N+1.
REQ-024 SHALL implement states IDLE, ACTIVE, DRAIN, SWAP.
REQ-025 IDLE -> ACTIVE: lcd_en high and ppu_mode==SCAN.
REQ-026 ACTIVE -> DRAIN: transition into V_BLANK.
REQ-027 DRAIN -> SWAP: FIFO empty.
REQ-028 SWAP -> ACTIVE: after exactly one cycle, during which fb_bank toggles and frame_done pulses.
REQ-029 SHALL, on lcd_en low in any state, flush FIFO, clear counters, deassert fb_wr_en next cycle and go to IDLE; fb_bank and overflow are retained.
REQ-030 SHALL ignore pixels arriving in DRAIN/SWAP/IDLE.

Reset
REQ-031 SHALL reset to: fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, fb_bank=0, frame_done=0, overflow=0, FIFO empty, x_cnt=y_cnt=0, state IDLE.
REQ-032 SHALL let reset override everything mid-frame, including a pending unacknowledged write.

Structure
REQ-033 SHALL place PPU mode encoding, FB_WIDTH=160, FB_HEIGHT=144 and the writer state typedef in the shared PPU package.
REQ-034 SHALL implement the FIFO as a sub-module ppu_px_fifo (sync, show-ahead, full/empty flags).

Verification
REQ-035 SHALL cover: bgp=0xE4, px_in 0,1,2,3 at line 0 x=0..3, ready=1 -> writes addr 0..3 data 0,1,2,3.
REQ-036 SHALL cover: bgp=0x1B, px_in=0 at y=2,x=5 -> addr 325, data 3.
REQ-037 SHALL cover: fb_wr_ready=0 for 20 pixels -> 16 stored, overflow=1, first 16 written in order once ready.
REQ-038 SHALL cover: 168 valid pixels in one line -> exactly 160 writes, addr ends at y*160+159.
REQ-039 SHALL cover: V_BLANK entry with 3 pending writes -> frame_done pulse only after third pop, fb_bank 0->1, next frame addr bit15=1.
REQ-040 SHALL cover: lcd_en dropped mid-line with FIFO non-empty -> fb_wr_en=0 next cycle, state IDLE, no further writes.
